// File: rtl/sixty_four_bit_seq_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sixty_four_bit_seq_adder_pkg
// Brief    : Shared widths, NZCV flag indices, FSM states and flag helper
//            for the sequential 64-bit adder.
// Revision : 1.0 - initial release
// ============================================================================
package sixty_four_bit_seq_adder_pkg;

    localparam int DATA_WIDTH = 64;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ADD  = 1'b1
    } state_t;

    // Overflow only when both operands share a sign that the result lacks.
    function automatic logic [3:0] calc_flags(
        input logic [DATA_WIDTH-1:0] res,
        input logic                  cout,
        input logic                  a_msb,
        input logic                  b_msb
    );
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = res[DATA_WIDTH-1];
        f[FLAG_Z] = (res == '0);
        f[FLAG_C] = cout;
        f[FLAG_V] = (a_msb == b_msb) && (res[DATA_WIDTH-1] != a_msb);
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sixty_four_bit_seq_adder_slice_adder.sv
`default_nettype none
// ============================================================================
// Module   : slice_adder
// Brief    : WIDTH-bit combinational adder with carry in and carry out.
// Revision : 1.0 - initial release
// ============================================================================
module slice_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH:0] w_total;

    assign w_total = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
    assign o_sum   = w_total[WIDTH-1:0];
    assign o_cout  = w_total[WIDTH];

endmodule
`default_nettype wire

// File: rtl/sixty_four_bit_seq_adder.sv
`default_nettype none
// ============================================================================
// Module   : sixty_four_bit_seq_adder
// Brief    : Multi-cycle 64-bit adder, one SLICE_WIDTH slice per clock, with
//            NZCV flags and a start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module sixty_four_bit_seq_adder
    import sixty_four_bit_seq_adder_pkg::*;
#(
    parameter int SLICE_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    input  logic                  carry_in,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  carry_out,
    output logic [3:0]            flags
);

    localparam int NUM_SLICES = DATA_WIDTH / SLICE_WIDTH;
    localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CNT_W-1:0]        r_cnt;
    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic [DATA_WIDTH-1:0]   r_res;
    logic                    r_carry;

    logic                    w_accept;
    logic                    w_last;
    int unsigned             w_base;
    logic [SLICE_WIDTH-1:0]  w_a_slice;
    logic [SLICE_WIDTH-1:0]  w_b_slice;
    logic [SLICE_WIDTH-1:0]  w_slice_sum;
    logic                    w_slice_cout;
    logic [DATA_WIDTH-1:0]   w_res_next;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_ADD;
                end
            end
            ST_ADD: begin
                busy = 1'b1;
                if (r_cnt == CNT_W'(NUM_SLICES - 1)) begin
                    w_last       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------- datapath
    // One adder is shared across all slices; the counter selects the lane.
    always_comb begin
        w_base    = int'(r_cnt) * SLICE_WIDTH;
        w_a_slice = r_a[w_base +: SLICE_WIDTH];
        w_b_slice = r_b[w_base +: SLICE_WIDTH];
    end

    slice_adder #(
        .WIDTH (SLICE_WIDTH)
    ) u_slice_adder (
        .i_a    (w_a_slice),
        .i_b    (w_b_slice),
        .i_cin  (r_carry),
        .o_sum  (w_slice_sum),
        .o_cout (w_slice_cout)
    );

    always_comb begin
        w_res_next                         = r_res;
        w_res_next[w_base +: SLICE_WIDTH]  = w_slice_sum;
    end

    // Visible outputs are loaded only on completion, never with partial sums.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_carry   <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            flags     <= 4'b0000;
        end else begin
            done <= w_last;
            if (w_accept) begin
                r_a     <= a_in;
                r_b     <= b_in;
                r_carry <= carry_in;
                r_res   <= '0;
                r_cnt   <= '0;
            end else if (r_state == ST_ADD) begin
                r_res   <= w_res_next;
                r_carry <= w_slice_cout;
                if (w_last) begin
                    r_cnt     <= '0;
                    sum       <= w_res_next;
                    carry_out <= w_slice_cout;
                    flags     <= calc_flags(w_res_next, w_slice_cout,
                                            r_a[DATA_WIDTH-1], r_b[DATA_WIDTH-1]);
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sixty_four_bit_seq_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sixty_four_bit_seq_adder
// Brief    : Directed self-checking bench for the sequential 64-bit adder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sixty_four_bit_seq_adder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] a_in;
    logic [63:0] b_in;
    logic        carry_in;
    logic        busy;
    logic        done;
    logic [63:0] sum;
    logic        carry_out;
    logic [3:0]  flags;

    int n_checks = 0;
    int n_errors = 0;
    int lat;
    bit seen;

    always #5 clk = ~clk;

    sixty_four_bit_seq_adder #(
        .SLICE_WIDTH (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .flags     (flags)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge, then scramble the operand ports.
    task automatic launch(input logic [63:0] a, input logic [63:0] b, input logic c);
        a_in     = a;
        b_in     = b;
        carry_in = c;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        a_in     = 64'hDEAD_BEEF_0BAD_F00D;
        b_in     = 64'h1234_5678_9ABC_DEF0;
        carry_in = ~c;
    endtask

    task automatic wait_done(output int l);
        l = 0;
        repeat (16) begin
            @(posedge clk); #1;
            l++;
            if (done === 1'b1) return;
        end
        l = 99;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        a_in     = '0;
        b_in     = '0;
        carry_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_done",  64'(done), 64'd0);
        check("rst_sum",   sum, 64'd0);
        check("rst_cout",  64'(carry_out), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        reset = 1'b0;

        // Basic add
        launch(64'd54, 64'd17, 1'b0);
        check("basic_busy", 64'(busy), 64'd1);
        wait_done(lat);
        check("basic_lat",   64'(lat), 64'd4);
        check("basic_sum",   sum, 64'd71);
        check("basic_cout",  64'(carry_out), 64'd0);
        check("basic_flags", 64'(flags), 64'b0000);

        // Negative operand; sum must hold old value mid-op
        launch(64'd54, 64'hFFFF_FFFF_FFFF_FFEF, 1'b0);
        @(posedge clk); #1;
        check("neg_hold",  sum, 64'd71);
        check("neg_nodone", 64'(done), 64'd0);
        wait_done(lat);
        check("neg_lat",   64'(lat), 64'd3);
        check("neg_sum",   sum, 64'd37);
        check("neg_cout",  64'(carry_out), 64'd1);
        check("neg_flags", 64'(flags), 64'b0010);

        // Cross-slice carry
        launch(64'h0000_0000_0000_FFFF, 64'd1, 1'b0);
        wait_done(lat);
        check("xs_sum",   sum, 64'h0000_0000_0001_0000);
        check("xs_flags", 64'(flags), 64'b0000);

        // Full wrap
        launch(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        wait_done(lat);
        check("wrap_sum",   sum, 64'd0);
        check("wrap_cout",  64'(carry_out), 64'd1);
        check("wrap_flags", 64'(flags), 64'b0110);

        // Signed overflow
        launch(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        wait_done(lat);
        check("ovf_sum",   sum, 64'h8000_0000_0000_0000);
        check("ovf_flags", 64'(flags), 64'b1001);

        // Carry-in only
        launch(64'd0, 64'd0, 1'b1);
        wait_done(lat);
        check("cin_sum",   sum, 64'd1);
        check("cin_flags", 64'(flags), 64'b0000);

        // start while busy is ignored
        launch(64'd5, 64'd6, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        a_in  = 64'd100;
        b_in  = 64'd200;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("ign_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        check("ign_done", 64'(done), 64'd1);
        check("ign_sum",  sum, 64'd11);
        @(posedge clk); #1;
        check("ign_idle", 64'(busy), 64'd0);
        check("ign_nodone", 64'(done), 64'd0);

        // Back-to-back: start held in the done cycle
        launch(64'd3, 64'd4, 1'b0);
        wait_done(lat);
        check("b2b_lat1", 64'(lat), 64'd4);
        check("b2b_sum1", sum, 64'd7);
        a_in     = 64'd10;
        b_in     = 64'd20;
        carry_in = 1'b1;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy", 64'(busy), 64'd1);
        wait_done(lat);
        check("b2b_lat2", 64'(lat), 64'd4);
        check("b2b_sum2", sum, 64'd31);

        // Reset mid-operation
        launch(64'h123, 64'h456, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mrst_busy",  64'(busy), 64'd0);
        check("mrst_done",  64'(done), 64'd0);
        check("mrst_sum",   sum, 64'd0);
        check("mrst_flags", 64'(flags), 64'd0);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done !== 1'b0) seen = 1'b1;
        end
        check("mrst_nodone", 64'(seen), 64'd0);
        launch(64'd1000, 64'd2000, 1'b0);
        wait_done(lat);
        check("mrst_lat",   64'(lat), 64'd4);
        check("mrst_sum2",  sum, 64'd3000);
        check("mrst_flags2", 64'(flags), 64'b0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
